// File: rtl/lc4_issue_scoreboard.sv
// ---------------------------------------------------------------------------
// lc4_issue_scoreboard
// In-order issue scheduler for the LC4 backend. Each cycle it decides, from
// the decoded fields of the instruction at issue and its own pending-write
// state, whether that instruction may fire. The decision is combinational
// (zero-cycle). It stalls on RAW, WAW and writeback-port (structural)
// hazards.
//
// State:
//   r_cnt[r]   down-counter per register; nonzero = write to r pending
//   r_cnt_nzp  down-counter for the NZP flags
//   r_rsv      one-hot-per-cycle reservations of the single writeback port;
//              bit i = a writeback happens i cycles from now
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_id_valid                    an instruction is presented for issue
//   i_id_r1sel/i_id_r1re          source 1 select / read enable
//   i_id_r2sel/i_id_r2re          source 2 select / read enable
//   i_id_wsel/i_id_regfile_we     destination select / write enable
//   i_id_nzp_we, i_id_is_branch   writes NZP / reads NZP
//   i_id_class                    latency class (ALU, MEM, MUL, DIV)
//   o_issue_fire, o_issue_stall   accepted this cycle / held by a hazard
//   o_stall_cause                 0 none, 1 RAW, 2 WAW, 3 writeback port
//   o_busy_regs, o_nzp_busy       pending-write flags
//   o_wb_rsv                      writeback reservation vector
// ---------------------------------------------------------------------------
module lc4_issue_scoreboard #(
  parameter int LAT_ALU = 1,
  parameter int LAT_MEM = 2,
  parameter int LAT_MUL = 4,
  parameter int LAT_DIV = 8,
  parameter int MAX_LAT = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_id_valid,
  input  logic [2:0]         i_id_r1sel,
  input  logic               i_id_r1re,
  input  logic [2:0]         i_id_r2sel,
  input  logic               i_id_r2re,
  input  logic [2:0]         i_id_wsel,
  input  logic               i_id_regfile_we,
  input  logic               i_id_nzp_we,
  input  logic               i_id_is_branch,
  input  logic [1:0]         i_id_class,
  output logic               o_issue_fire,
  output logic               o_issue_stall,
  output logic [1:0]         o_stall_cause,
  output logic [7:0]         o_busy_regs,
  output logic               o_nzp_busy,
  output logic [MAX_LAT-1:0] o_wb_rsv
);

  localparam int CW = $clog2(MAX_LAT + 1);

  logic [CW-1:0]      r_cnt [8];
  logic [CW-1:0]      r_cnt_nzp;
  logic [MAX_LAT-1:0] r_rsv;

  logic [7:0]         w_busy;
  logic               w_nzp_busy;
  logic [CW-1:0]      w_lat;
  logic               w_wr;
  logic               w_raw;
  logic               w_waw;
  logic               w_struct;
  logic               w_hazard;
  logic               w_fire;
  logic [MAX_LAT-1:0] w_rsv_at_lat;
  logic [MAX_LAT-1:0] w_rsv_new;

  always_comb begin
    for (int r = 0; r < 8; r++) begin
      w_busy[r] = (r_cnt[r] != '0);
    end
  end

  assign w_nzp_busy = (r_cnt_nzp != '0);

  always_comb begin
    case (i_id_class)
      2'b00:   w_lat = CW'(LAT_ALU);
      2'b01:   w_lat = CW'(LAT_MEM);
      2'b10:   w_lat = CW'(LAT_MUL);
      default: w_lat = CW'(LAT_DIV);
    endcase
  end

  assign w_wr = i_id_regfile_we | i_id_nzp_we;

  // Reads see only the current busy state, so an instruction never stalls
  // on its own destination (ADD R1,R1,R2).
  assign w_raw = (i_id_r1re & w_busy[i_id_r1sel]) |
                 (i_id_r2re & w_busy[i_id_r2sel]) |
                 (i_id_is_branch & w_nzp_busy);
  assign w_waw = (i_id_regfile_we & w_busy[i_id_wsel]) |
                 (i_id_nzp_we & w_nzp_busy);

  // Shifting right by L puts rsv[L] in bit 0; L >= MAX_LAT shifts it all
  // out, which gives the "reads as 0" behaviour for free.
  assign w_rsv_at_lat = r_rsv >> w_lat;
  assign w_struct     = w_wr & w_rsv_at_lat[0];

  // Reservation lands at L-1 because the vector shifts on the same edge.
  assign w_rsv_new = {{(MAX_LAT-1){1'b0}}, 1'b1} << (w_lat - 1'b1);

  assign w_hazard = w_raw | w_waw | w_struct;
  assign w_fire   = i_id_valid & ~w_hazard;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < 8; r++) begin
        r_cnt[r] <= '0;
      end
      r_cnt_nzp <= '0;
      r_rsv     <= '0;
    end else begin
      for (int r = 0; r < 8; r++) begin
        if (w_fire && i_id_regfile_we && (i_id_wsel == 3'(r))) begin
          r_cnt[r] <= w_lat;
        end else if (w_busy[r]) begin
          r_cnt[r] <= r_cnt[r] - 1'b1;
        end
      end
      if (w_fire && i_id_nzp_we) begin
        r_cnt_nzp <= w_lat;
      end else if (w_nzp_busy) begin
        r_cnt_nzp <= r_cnt_nzp - 1'b1;
      end
      r_rsv <= (r_rsv >> 1) | ((w_fire && w_wr) ? w_rsv_new : '0);
    end
  end

  always_comb begin
    o_issue_fire  = 1'b0;
    o_issue_stall = 1'b0;
    o_stall_cause = 2'd0;
    if (!i_rst) begin
      o_issue_fire  = w_fire;
      o_issue_stall = i_id_valid & w_hazard;
      if (i_id_valid) begin
        if (w_raw)         o_stall_cause = 2'd1;
        else if (w_waw)    o_stall_cause = 2'd2;
        else if (w_struct) o_stall_cause = 2'd3;
      end
    end
  end

  assign o_busy_regs = w_busy;
  assign o_nzp_busy  = w_nzp_busy;
  assign o_wb_rsv    = r_rsv;

  // A newly reserved writeback slot must never already be taken.
  a_wb_unique: assert property (@(posedge i_clk) disable iff (i_rst)
    (w_fire && w_wr) |-> (((r_rsv >> 1) & w_rsv_new) == '0));

endmodule
